// File: rtl/divider_scheduler.sv
`default_nettype none
// ============================================================================
// divider_scheduler : round-robin sharing of one pipelined divider with tag
//   tracking, flush and drain. Optional macro: DIV_SCHED_DIVZERO_BYPASS_EN
// Revision: 1.0
// ============================================================================
module divider_scheduler #(
    parameter int DATA_LEN    = 32,
    parameter int NUM_REQ     = 4,
    parameter int DIV_LATENCY = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_LEN-1:0] req_a,
    input  logic [NUM_REQ*DATA_LEN-1:0] req_b,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        rsp_valid,
    output logic [$clog2(NUM_REQ)-1:0]  rsp_id,
    output logic [DATA_LEN-1:0]         rsp_result,
    output logic                        rsp_divzero,
    input  logic                        flush,
    input  logic                        drain,
    output logic                        drained,
    output logic                        busy,
    output logic                        div_reset,
    output logic [DATA_LEN-1:0]         div_a,
    output logic [DATA_LEN-1:0]         div_b,
    input  logic [DATA_LEN-1:0]         div_result
);
    localparam int ID_W = $clog2(NUM_REQ);
    // Slot 0 travels alongside div_a/div_b; slot TAIL lines up with div_result.
    localparam int TAIL = DIV_LATENCY;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ID_W-1:0]     r_last_grant;
    logic [NUM_REQ-1:0]  w_grant;
    logic [ID_W-1:0]     w_grant_id;
    logic [ID_W-1:0]     w_idx;
    logic                w_handshake;
    logic [DATA_LEN-1:0] w_op_a;
    logic [DATA_LEN-1:0] w_op_b;
    logic [DATA_LEN-1:0] w_issue_b;
    logic                w_divzero;

    logic                r_div_reset;
    logic [DATA_LEN-1:0] r_div_a;
    logic [DATA_LEN-1:0] r_div_b;
    logic [TAIL:0]       r_tag_vld;
    logic [TAIL:0]       r_tag_dz;
    logic [ID_W-1:0]     r_tag_id [0:TAIL];
    logic                r_rsp_valid;
    logic [ID_W-1:0]     r_rsp_id;
    logic [DATA_LEN-1:0] r_rsp_result;
    logic                r_rsp_divzero;

    // Walk from lowest to highest priority so the nearest requester after
    // r_last_grant is the final (winning) assignment.
    always_comb begin
        w_grant    = '0;
        w_grant_id = '0;
        w_idx      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_idx = ID_W'((int'(r_last_grant) + k) % NUM_REQ);
            if (req_valid[w_idx]) begin
                w_grant        = '0;
                w_grant[w_idx] = 1'b1;
                w_grant_id     = w_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = '0;
        if (flush) begin
            w_state_nxt = ST_FLUSH;
        end else if (drain) begin
            w_state_nxt = ST_DRAIN;
        end else begin
            w_state_nxt = ST_RUN;
        end
        if (r_state == ST_RUN && !flush) begin
            req_ready = w_grant;
        end
    end

    assign w_handshake = |req_ready;
    assign w_op_a      = req_a[w_grant_id*DATA_LEN +: DATA_LEN];
    assign w_op_b      = req_b[w_grant_id*DATA_LEN +: DATA_LEN];

`ifdef DIV_SCHED_DIVZERO_BYPASS_EN
    assign w_divzero = (w_op_b == '0);
    assign w_issue_b = w_divzero ? DATA_LEN'(1) : w_op_b;
`else
    assign w_divzero = 1'b0;
    assign w_issue_b = w_op_b;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_grant  <= ID_W'(NUM_REQ - 1);
            r_div_reset   <= 1'b1;
            r_div_a       <= '0;
            r_div_b       <= '0;
            r_tag_vld     <= '0;
            r_tag_dz      <= '0;
            for (int i = 0; i <= TAIL; i++) begin
                r_tag_id[i] <= '0;
            end
            r_rsp_valid   <= 1'b0;
            r_rsp_id      <= '0;
            r_rsp_result  <= '0;
            r_rsp_divzero <= 1'b0;
        end else begin
            r_div_reset <= flush;
            r_div_a     <= w_handshake ? w_op_a : '0;
            r_div_b     <= w_handshake ? w_issue_b : '0;
            if (w_handshake) begin
                r_last_grant <= w_grant_id;
            end
            r_tag_vld   <= flush ? '0 : {r_tag_vld[TAIL-1:0], w_handshake};
            r_tag_dz    <= {r_tag_dz[TAIL-1:0], w_handshake & w_divzero};
            r_tag_id[0] <= w_grant_id;
            for (int i = 1; i <= TAIL; i++) begin
                r_tag_id[i] <= r_tag_id[i-1];
            end
            // A result reaching the tail on the flush edge is dropped as well.
            r_rsp_valid <= r_tag_vld[TAIL] && !flush;
            if (r_tag_vld[TAIL] && !flush) begin
                r_rsp_id      <= r_tag_id[TAIL];
                r_rsp_result  <= r_tag_dz[TAIL] ? '1 : div_result;
                r_rsp_divzero <= r_tag_dz[TAIL];
            end
        end
    end

    assign busy        = (|r_tag_vld) | r_rsp_valid;
    assign drained     = (r_state == ST_DRAIN) && !busy;
    assign div_reset   = r_div_reset;
    assign div_a       = r_div_a;
    assign div_b       = r_div_b;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_rsp_id;
    assign rsp_result  = r_rsp_result;
    assign rsp_divzero = r_rsp_divzero;

endmodule
`default_nettype wire

// File: tb/tb_divider_scheduler.sv
`default_nettype none
// ============================================================================
// tb_divider_scheduler : randomized self-checking bench with a divider model
//   and a transaction-level response predictor.
// Revision: 1.0
// ============================================================================
module tb_divider_scheduler;
    localparam int DATA_LEN  = 32;
    localparam int NUM_REQ   = 4;
    localparam int LAT       = 16;
    localparam int ID_W      = 2;
    localparam int RSP_DELAY = LAT + 2;
    localparam int M_RUN     = 0;
    localparam int M_DRAIN   = 1;
    localparam int M_FLUSH   = 2;

    logic                        clk       = 1'b0;
    logic                        reset_n   = 1'b0;
    logic [NUM_REQ-1:0]          req_valid = '0;
    logic [NUM_REQ*DATA_LEN-1:0] req_a;
    logic [NUM_REQ*DATA_LEN-1:0] req_b;
    logic [NUM_REQ-1:0]          req_ready;
    logic                        rsp_valid;
    logic [ID_W-1:0]             rsp_id;
    logic [DATA_LEN-1:0]         rsp_result;
    logic                        rsp_divzero;
    logic                        flush = 1'b0;
    logic                        drain = 1'b0;
    logic                        drained;
    logic                        busy;
    logic                        div_reset;
    logic [DATA_LEN-1:0]         div_a;
    logic [DATA_LEN-1:0]         div_b;
    logic [DATA_LEN-1:0]         div_result;
    logic [DATA_LEN-1:0]         opa [NUM_REQ];
    logic [DATA_LEN-1:0]         opb [NUM_REQ];

    divider_scheduler #(
        .DATA_LEN    (DATA_LEN),
        .NUM_REQ     (NUM_REQ),
        .DIV_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_result  (rsp_result),
        .rsp_divzero (rsp_divzero),
        .flush       (flush),
        .drain       (drain),
        .drained     (drained),
        .busy        (busy),
        .div_reset   (div_reset),
        .div_a       (div_a),
        .div_b       (div_b),
        .div_result  (div_result)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*DATA_LEN +: DATA_LEN] = opa[i];
            req_b[i*DATA_LEN +: DATA_LEN] = opb[i];
        end
    end

    function automatic logic [DATA_LEN-1:0] raw_quot(input logic [DATA_LEN-1:0] a,
                                                     input logic [DATA_LEN-1:0] b);
        return (b == '0) ? '1 : a / b;
    endfunction

    function automatic logic [DATA_LEN-1:0] issued_b(input logic [DATA_LEN-1:0] b);
`ifdef DIV_SCHED_DIVZERO_BYPASS_EN
        if (b == '0) return DATA_LEN'(1);
`endif
        return b;
    endfunction

    // {divzero, result} a requester should see for operands a, b
    function automatic logic [DATA_LEN:0] exp_rsp(input logic [DATA_LEN-1:0] a,
                                                  input logic [DATA_LEN-1:0] b);
`ifdef DIV_SCHED_DIVZERO_BYPASS_EN
        if (b == '0) return {1'b1, {DATA_LEN{1'b1}}};
`endif
        return {1'b0, raw_quot(a, b)};
    endfunction

    // Divider: DIV_LATENCY-stage pipeline with active-high sync reset.
    logic [DATA_LEN-1:0] dpipe [LAT];
    always @(posedge clk) begin
        if (div_reset) begin
            for (int i = 0; i < LAT; i++) dpipe[i] <= '0;
        end else begin
            dpipe[0] <= raw_quot(div_a, div_b);
            for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
        end
    end
    assign div_result = dpipe[LAT-1];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, got, exp, $time);
    endtask

    typedef struct {
        int                  arrival;
        int                  id;
        logic [DATA_LEN-1:0] res;
        logic                dz;
    } exp_t;

    exp_t                q[$];
    int                  mode     = M_RUN;
    int                  last     = NUM_REQ - 1;
    int                  cyc      = 0;
    bit                  rst_tail = 1'b0;
    logic [DATA_LEN-1:0] exp_div_a = '0;
    logic [DATA_LEN-1:0] exp_div_b = '0;

    always @(negedge clk) begin
        logic [NUM_REQ-1:0] exp_ready;
        logic [DATA_LEN:0]  er;
        exp_t               e;
        bit                 exp_busy;
        int                 gid;
        cyc++;
        if (!reset_n) begin
            check("rst_req_ready", 64'(req_ready), 64'(0));
            check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
            check("rst_rsp_id", 64'(rsp_id), 64'(0));
            check("rst_rsp_result", 64'(rsp_result), 64'(0));
            check("rst_rsp_divzero", 64'(rsp_divzero), 64'(0));
            check("rst_busy", 64'(busy), 64'(0));
            check("rst_drained", 64'(drained), 64'(0));
            check("rst_div_reset", 64'(div_reset), 64'(1));
            check("rst_div_a", 64'(div_a), 64'(0));
            check("rst_div_b", 64'(div_b), 64'(0));
            q.delete();
            mode      = M_RUN;
            last      = NUM_REQ - 1;
            rst_tail  = 1'b1;
            exp_div_a = '0;
            exp_div_b = '0;
        end else begin
            exp_ready = '0;
            gid       = -1;
            if (mode == M_RUN && !flush) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    if (gid < 0 && req_valid[(last + k) % NUM_REQ]) gid = (last + k) % NUM_REQ;
                end
            end
            if (gid >= 0) exp_ready[gid] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(exp_ready));
            check("div_a", 64'(div_a), 64'(exp_div_a));
            check("div_b", 64'(div_b), 64'(exp_div_b));
            exp_busy = (q.size() != 0);
            check("busy", 64'(busy), 64'(exp_busy));
            check("drained", 64'(drained), 64'((mode == M_DRAIN) && !exp_busy));
            check("div_reset", 64'(div_reset), 64'((mode == M_FLUSH) || rst_tail));
            rst_tail = 1'b0;
            if (q.size() != 0 && q[0].arrival == cyc) begin
                check("rsp_valid", 64'(rsp_valid), 64'(1));
                check("rsp_id", 64'(rsp_id), 64'(q[0].id));
                check("rsp_result", 64'(rsp_result), 64'(q[0].res));
                check("rsp_divzero", 64'(rsp_divzero), 64'(q[0].dz));
                void'(q.pop_front());
            end else begin
                check("rsp_valid", 64'(rsp_valid), 64'(0));
            end
            exp_div_a = '0;
            exp_div_b = '0;
            if (gid >= 0) begin
                er        = exp_rsp(opa[gid], opb[gid]);
                e.arrival = cyc + RSP_DELAY;
                e.id      = gid;
                e.res     = er[DATA_LEN-1:0];
                e.dz      = er[DATA_LEN];
                q.push_back(e);
                last      = gid;
                exp_div_a = opa[gid];
                exp_div_b = issued_b(opb[gid]);
            end
            if (flush) q.delete();
            mode = flush ? M_FLUSH : (drain ? M_DRAIN : M_RUN);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // One op from requester id; reports latency from handshake to response.
    task automatic send_one(input int id, input logic [DATA_LEN-1:0] a,
                            input logic [DATA_LEN-1:0] b, output int lat,
                            output logic [DATA_LEN-1:0] res, output logic dz);
        int t0;
        tick();
        opa[id]        = a;
        opb[id]        = b;
        req_valid      = '0;
        req_valid[id]  = 1'b1;
        t0             = -1;
        for (int n = 0; n < 10 && t0 < 0; n++) begin
            @(negedge clk);
            #1;
            if (req_ready[id]) t0 = cyc;
        end
        tick();
        req_valid[id] = 1'b0;
        check("grant_seen", 64'(t0 >= 0), 64'(1));
        lat = -1;
        res = '0;
        dz  = 1'b0;
        for (int n = 0; n < 40 && lat < 0 && t0 >= 0; n++) begin
            @(negedge clk);
            #1;
            if (rsp_valid && rsp_id == ID_W'(id)) begin
                lat = cyc - t0;
                res = rsp_result;
                dz  = rsp_divzero;
            end
        end
    endtask

    initial begin
        int                  lat;
        int                  bad;
        int                  cnt;
        bit                  seen;
        logic [DATA_LEN-1:0] res;
        logic                dz;

        for (int i = 0; i < NUM_REQ; i++) begin
            opa[i] = '0;
            opb[i] = DATA_LEN'(1);
        end
        @(posedge clk);
        #1;
        check("init_div_reset", 64'(div_reset), 64'(1));
        check("init_rsp_valid", 64'(rsp_valid), 64'(0));
        idle(2);
        reset_n = 1'b1;

        // fairness: all requesters request for 8 cycles
        tick();
        req_valid = '1;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                opa[i] = $urandom;
                opb[i] = $urandom_range(1, 5000);
            end
            @(negedge clk);
            #1;
            check("fair_grant", 64'(req_ready), 64'(NUM_REQ'(1) << (n % NUM_REQ)));
            tick();
        end
        req_valid = '0;
        idle(22);

        // single op
        send_one(0, 100, 7, lat, res, dz);
        check("single_latency", 64'(lat), 64'(18));
        check("single_result", 64'(res), 64'(14));
        idle(2);
        check("single_busy_after", 64'(busy), 64'(0));

        // flush with three ops in flight
        req_valid = 4'b0111;
        idle(3);
        req_valid = '0;
        idle(4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        cnt = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            #1;
            if (rsp_valid) cnt++;
        end
        check("flush_no_rsp", 64'(cnt), 64'(0));
        send_one(0, 81, 9, lat, res, dz);
        check("flush_new_latency", 64'(lat), 64'(18));
        check("flush_new_result", 64'(res), 64'(9));

        // drain with two ops in flight
        tick();
        for (int i = 0; i < NUM_REQ; i++) begin
            opa[i] = $urandom;
            opb[i] = $urandom_range(1, 300);
        end
        req_valid = 4'b0011;
        idle(2);
        drain     = 1'b1;
        req_valid = '0;
        tick();
        req_valid = '1;
        bad  = 0;
        cnt  = 0;
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            #1;
            if (req_ready != '0) bad++;
            if (rsp_valid) cnt++;
            if (drained) seen = 1'b1;
        end
        check("drain_no_grant", 64'(bad), 64'(0));
        check("drain_rsp_count", 64'(cnt), 64'(2));
        check("drained_seen", 64'(seen), 64'(1));
        tick();
        drain = 1'b0;
        tick();
        @(negedge clk);
        #1;
        check("drain_resume", 64'(|req_ready), 64'(1));
        tick();
        req_valid = '0;
        idle(22);

        // divide by zero
        send_one(2, 5, 0, lat, res, dz);
        check("dz_latency", 64'(lat), 64'(18));
        check("dz_result", 64'(res), 64'(32'hFFFF_FFFF));
`ifdef DIV_SCHED_DIVZERO_BYPASS_EN
        check("dz_flag", 64'(dz), 64'(1));
`else
        check("dz_flag", 64'(dz), 64'(0));
`endif

        // asynchronous reset with four ops in flight
        tick();
        req_valid = '1;
        idle(4);
        req_valid = '0;
        idle(3);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_div_reset", 64'(div_reset), 64'(1));
        check("arst_div_a", 64'(div_a), 64'(0));
        check("arst_req_ready", 64'(req_ready), 64'(0));
        idle(2);
        reset_n = 1'b1;
        idle(25);

        // randomized traffic with occasional flush and drain
        for (int n = 0; n < 600; n++) begin
            tick();
            req_valid = NUM_REQ'($urandom);
            for (int i = 0; i < NUM_REQ; i++) begin
                opa[i] = $urandom;
                opb[i] = ($urandom_range(0, 9) == 0) ? '0 : DATA_LEN'($urandom_range(1, 1000));
            end
            flush = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 29) == 0) drain = ~drain;
        end
        tick();
        req_valid = '0;
        flush     = 1'b0;
        drain     = 1'b0;
        idle(25);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
